// File: rtl/fbw_pkg.sv
// ============================================================================
// Module   : fbw_pkg
// Purpose  : Shared state/grant encodings and default sizing for fb_write_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fbw_pkg;

  localparam int c_NPIX_DEFAULT = 19200;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } fbw_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CAM  = 2'd1,
    GNT_HOST = 2'd2
  } fbw_gnt_e;

endpackage

`default_nettype wire

// File: rtl/fb_write_arbiter_if.sv
// ============================================================================
// Module   : fb_write_arbiter_if
// Purpose  : Camera, host, clear and RAM-write signal bundle.
//            frame_pix_cnt exists only when FBW_PIXCNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fb_write_arbiter_if #(
  parameter int AW = 17,
  parameter int DW = 16
);
  logic          cam_sof;
  logic          cam_valid;
  logic [DW-1:0] cam_data;
  logic          cam_ready;
  logic          host_valid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;
  logic          host_ready;
  logic          clr_start;
  logic [DW-1:0] clr_color;
  logic          clr_busy;
  logic          clr_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_we;
`ifdef FBW_PIXCNT_EN
  logic [15:0]   frame_pix_cnt;
`endif

  modport slave (
`ifdef FBW_PIXCNT_EN
    output frame_pix_cnt,
`endif
    input  cam_sof, cam_valid, cam_data, host_valid, host_addr, host_data,
           clr_start, clr_color,
    output cam_ready, host_ready, clr_busy, clr_done, mem_addr, mem_data, mem_we
  );

  modport master (
`ifdef FBW_PIXCNT_EN
    input  frame_pix_cnt,
`endif
    output cam_sof, cam_valid, cam_data, host_valid, host_addr, host_data,
           clr_start, clr_color,
    input  cam_ready, host_ready, clr_busy, clr_done, mem_addr, mem_data, mem_we
  );

endinterface

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-requester round-robin arbiter; req[0]=camera, req[1]=host.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import fbw_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  fbw_gnt_e r_last;
  fbw_gnt_e w_gnt;

  always_comb begin
    w_gnt = GNT_NONE;
    if (en) begin
      if (req == 2'b11)
        w_gnt = (r_last == GNT_HOST) ? GNT_CAM : GNT_HOST;
      else if (req[0])
        w_gnt = GNT_CAM;
      else if (req[1])
        w_gnt = GNT_HOST;
    end
  end

  assign gnt = {w_gnt == GNT_HOST, w_gnt == GNT_CAM};

  // Starting from HOST lets the camera win the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_last <= GNT_HOST;
    else if (w_gnt != GNT_NONE)
      r_last <= w_gnt;
  end

endmodule

`default_nettype wire

// File: rtl/fb_write_arbiter.sv
// ============================================================================
// Module   : fb_write_arbiter
// Purpose  : Shares the framebuffer RAM write port between camera, host and a
//            clear engine. Define FBW_PIXCNT_EN to add per-frame pixel counting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_write_arbiter
  import fbw_pkg::*;
#(
  parameter int AW   = 17,
  parameter int DW   = 16,
  parameter int NPIX = c_NPIX_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  fb_write_arbiter_if.slave   bus
);

  if ((NPIX < 1) || (longint'(NPIX) > (longint'(1) << AW))) begin : g_npix_check
    $error("fb_write_arbiter: NPIX must be in 1..2**AW");
  end

  localparam logic [AW-1:0] c_LAST = AW'(NPIX - 1);

  fbw_state_e    r_state;
  fbw_state_e    w_state_nxt;
  logic [AW-1:0] r_cam_cnt;
  logic [AW-1:0] r_clr_cnt;
  logic [DW-1:0] r_clr_color;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_data;
  logic          r_clr_done;

  logic [1:0]    w_gnt;
  logic          w_arb_en;
  logic          w_cam_acc;
  logic          w_host_acc;
  logic          w_clr_last;
  logic [AW-1:0] w_cam_addr;
  logic [AW-1:0] w_cam_nxt;

  // A clear request pre-empts both sources in the cycle it is seen.
  assign w_arb_en = (r_state == ST_RUN) && !bus.clr_start;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_arb_en),
    .req   ({bus.host_valid, bus.cam_valid}),
    .gnt   (w_gnt)
  );

  assign w_cam_acc  = w_gnt[0];
  assign w_host_acc = w_gnt[1];
  assign w_clr_last = (r_clr_cnt == c_LAST);
  assign w_cam_addr = bus.cam_sof ? '0 : r_cam_cnt;
  assign w_cam_nxt  = (w_cam_addr == c_LAST) ? '0 : w_cam_addr + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (bus.clr_start) w_state_nxt = ST_CLEAR;
      ST_CLEAR: if (w_clr_last)    w_state_nxt = ST_RUN;
      default:                     w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_RUN;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cam_cnt <= '0;
    end else if (w_cam_acc) begin
      r_cam_cnt <= w_cam_nxt;
    end else if (bus.cam_sof) begin
      r_cam_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_cnt   <= '0;
      r_clr_color <= '0;
    end else if (r_state == ST_RUN) begin
      if (bus.clr_start) begin
        r_clr_cnt   <= '0;
        r_clr_color <= bus.clr_color;
      end
    end else begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  // Single registered write stage; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_clr_done <= 1'b0;
    end else begin
      r_mem_we   <= 1'b0;
      r_clr_done <= 1'b0;
      if (r_state == ST_CLEAR) begin
        r_mem_we   <= 1'b1;
        r_mem_addr <= r_clr_cnt;
        r_mem_data <= r_clr_color;
        r_clr_done <= w_clr_last;
      end else if (w_cam_acc) begin
        r_mem_we   <= 1'b1;
        r_mem_addr <= w_cam_addr;
        r_mem_data <= bus.cam_data;
      end else if (w_host_acc) begin
        r_mem_we   <= 1'b1;
        r_mem_addr <= bus.host_addr;
        r_mem_data <= bus.host_data;
      end
    end
  end

  assign bus.cam_ready  = w_cam_acc;
  assign bus.host_ready = w_host_acc;
  assign bus.clr_busy   = (r_state == ST_CLEAR);
  assign bus.clr_done   = r_clr_done;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_data   = r_mem_data;

`ifdef FBW_PIXCNT_EN
  logic [15:0] r_pix_acc;
  logic [15:0] r_frame_pix;
  logic [15:0] w_pix_sum;

  assign w_pix_sum = (r_pix_acc == 16'hFFFF) ? r_pix_acc : r_pix_acc + {15'd0, w_cam_acc};

  // The beat coinciding with SOF is counted in both the closing and the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_acc   <= '0;
      r_frame_pix <= '0;
    end else if (bus.cam_sof) begin
      r_frame_pix <= w_pix_sum;
      r_pix_acc   <= {15'd0, w_cam_acc};
    end else begin
      r_pix_acc <= w_pix_sum;
    end
  end

  assign bus.frame_pix_cnt = r_frame_pix;
`endif

endmodule

`default_nettype wire

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Sequences and shares the single write port (address, data, write-enable) of the dual-port framebuffer RAM.
- Three write sources:
  - Camera pixel stream, auto-addressed.
  - Host/CPU random-access writes.
  - Internal clear engine that fills the visible frame with one colour.
- Sits between the capture/host logic and the RAM write port; the RAM read port (VGA side) is untouched.

Parameters:
- AW, 17, RAM address width in bits.
- DW, 16, RAM data width in bits.
- NPIX, 19200, visible pixel count (160x120); camera wrap point and clear range.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cam_sof  in  1  camera start-of-frame pulse; resets camera address counter.
- cam_valid  in  1  camera pixel valid.
- cam_data  in  DW  camera pixel.
- cam_ready  out  1  camera beat accepted this cycle when cam_valid is also high.
- host_valid  in  1  host write request.
- host_addr  in  AW  host write address (full 2^AW space allowed).
- host_data  in  DW  host write data.
- host_ready  out  1  host beat accepted this cycle when host_valid is also high.
- clr_start  in  1  start-clear pulse.
- clr_color  in  DW  clear value, sampled on the accepted clr_start.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse on the final clear write.
- mem_addr  out  AW  to RAM write address.
- mem_data  out  DW  to RAM write data.
- mem_we  out  1  to RAM write enable.

Behaviour:
- Reset: all outputs 0; state RUN; camera counter 0; last_grant = HOST, so the camera wins the first tie.
- State RUN:
  - Grant is combinational.
  - Only one of cam_valid/host_valid high: that source is granted.
  - Both high: round-robin; the source not granted last wins.
  - The ready of the granted source is 1, the other 0.
  - A source must hold valid and data until accepted.
- Accepted beat at edge N drives mem_we=1, mem_addr and mem_data at N+1 (one registered stage). mem_we=0 in any cycle with no accepted beat.
- Camera address:
  - Write goes to cam_cnt, then cam_cnt increments.
  - At NPIX-1 it wraps to 0.
- cam_sof:
  - Sets cam_cnt to 0 at any time, including during CLEAR.
  - If cam_sof coincides with an accepted camera beat, that beat writes address 0 and cam_cnt becomes 1.
- clr_start in RUN:
  - Enter CLEAR next edge; latch clr_color; clear address starts at 0.
  - Takes priority over any pending camera/host beat in that cycle; neither is accepted.
- State CLEAR:
  - One write per cycle at addresses 0..NPIX-1 with the latched colour.
  - cam_ready=0 and host_ready=0; clr_busy=1.
  - clr_start is ignored.
  - The final write (address NPIX-1) raises clr_done for exactly that cycle, aligned with its mem_we.
  - Next state is RUN; clr_busy falls in the same cycle as the final write.
- Clear duration is exactly NPIX write cycles.
- rst_n low mid-clear: clear aborted immediately, outputs 0, no clr_done.
- Address arithmetic is unsigned AW-bit. NPIX must be ≤ 2^AW; the implementation checks this statically.

Optional Feature:
- FBW_PIXCNT_EN defined:
  - Adds output frame_pix_cnt [15:0].
  - Internal 16-bit saturating counter of accepted camera beats.
  - At cam_sof, the counter value (including a beat accepted that same cycle) is copied to frame_pix_cnt, and the counter restarts (at 1 if a beat coincides, else 0).
  - frame_pix_cnt resets to 0.
- FBW_PIXCNT_EN undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package fbw_pkg:
  - State encoding (ST_RUN, ST_CLEAR).
  - Grant encoding (GNT_NONE, GNT_CAM, GNT_HOST).
  - Default NPIX constant.
- One sub-module, rr_arb2: two-requester round-robin arbiter with last-grant register, producing the grant vector.

Test Plan:
- Camera only, 5 beats after cam_sof, data 0x0001..0x0005 -> writes to addresses 0..4 with matching data, each one cycle after its accept.
- cam_valid and host_valid held continuously, host_addr=0x1F000 -> grants alternate CAM, HOST, CAM, HOST; first grant is CAM; host writes land at 0x1F000.
- Camera streams NPIX+2 beats without cam_sof -> addresses 19198, 19199, 0, 1.
- clr_start with clr_color=0xF800 while the host is pending -> exactly 19200 writes of 0xF800 at addresses 0..19199; host_ready held 0 throughout; clr_done single pulse on address 19199; host accepted next cycle.
- rst_n asserted at clear address 100 -> mem_we=0 and clr_busy=0 immediately, no clr_done; after release, a camera beat writes address 0.
- FBW_PIXCNT_EN: 300 beats, then cam_sof -> frame_pix_cnt=300; a cam_sof with a coincident beat gives the next frame a count starting at 1.
